// File: rtl/coriolis_pkg.sv
// Shared constants and fixed-point helper functions for the Coriolis kernel pipeline.
package coriolis_pkg;

   localparam int LAT  = 3;
   localparam int MAXW = 128;

   typedef logic signed [MAXW-1:0] wide_t;

   function automatic wide_t pow2(input int n);
      return wide_t'(1) <<< n;
   endfunction

   function automatic wide_t round_const(input int fracw);
      return pow2(fracw - 1);
   endfunction

   function automatic wide_t sat_hi(input int dataw);
      return pow2(dataw - 1) - wide_t'(1);
   endfunction

   function automatic wide_t sat_lo(input int dataw);
      return -pow2(dataw - 1);
   endfunction

endpackage

// File: rtl/coriolis_lane.sv
// Single-lane datapath: multiply, add/sub with round-half-up, reduce to DATAW.
// Reduction saturates when CORIOLIS_SATURATE_EN is defined, otherwise wraps.
module coriolis_lane
   import coriolis_pkg::*;
#(
   parameter int DATAW = 34,
   parameter int FRACW = 16
) (
   input  logic                    clk,
   input  logic signed [DATAW-1:0] u,
   input  logic signed [DATAW-1:0] v,
   input  logic signed [DATAW-1:0] coef_a,
   input  logic signed [DATAW-1:0] coef_b,
   output logic signed [DATAW-1:0] un,
   output logic signed [DATAW-1:0] vn,
   output logic                    ovf
);

   localparam int PW = 2 * DATAW;
   localparam int SW = 2 * DATAW + 1;
   localparam logic signed [SW-1:0] RND = SW'(round_const(FRACW));
`ifdef CORIOLIS_SATURATE_EN
   localparam logic signed [SW-1:0] SAT_HI = SW'(sat_hi(DATAW));
   localparam logic signed [SW-1:0] SAT_LO = SW'(sat_lo(DATAW));
`endif

   logic signed [PW-1:0] ua_p0, vb_p0, va_p0, ub_p0;
   logic signed [SW-1:0] un_p1, vn_p1;

   function automatic logic signed [PW-1:0] mul(input logic signed [DATAW-1:0] x,
                                                input logic signed [DATAW-1:0] y);
      logic signed [PW-1:0] xe;
      logic signed [PW-1:0] ye;
      xe = PW'(x);
      ye = PW'(y);
      return xe * ye;
   endfunction

   function automatic logic signed [SW-1:0] round_shift(input logic signed [SW-1:0] s);
      return (s + RND) >>> FRACW;
   endfunction

   function automatic logic signed [DATAW-1:0] reduce(input logic signed [SW-1:0] x);
`ifdef CORIOLIS_SATURATE_EN
      if (x > SAT_HI) return SAT_HI[DATAW-1:0];
      if (x < SAT_LO) return SAT_LO[DATAW-1:0];
`endif
      return x[DATAW-1:0];
   endfunction

`ifdef CORIOLIS_SATURATE_EN
   function automatic logic clamps(input logic signed [SW-1:0] x);
      return (x > SAT_HI) || (x < SAT_LO);
   endfunction
`endif

   // stage p0: products
   always_ff @(posedge clk) begin
      ua_p0 <= mul(u, coef_a);
      vb_p0 <= mul(v, coef_b);
      va_p0 <= mul(v, coef_a);
      ub_p0 <= mul(u, coef_b);
   end

   // stage p1: sum/difference at full precision, rounded and scaled
   always_ff @(posedge clk) begin
      un_p1 <= round_shift(SW'(ua_p0) + SW'(vb_p0));
      vn_p1 <= round_shift(SW'(va_p0) - SW'(ub_p0));
   end

   // stage p2: reduction, registered by the output buffer in the top
   assign un = reduce(un_p1);
   assign vn = reduce(vn_p1);

`ifdef CORIOLIS_SATURATE_EN
   assign ovf = clamps(un_p1) | clamps(vn_p1);
`else
   logic unused_hi;
   assign unused_hi = ^{un_p1[SW-1:DATAW], vn_p1[SW-1:DATAW]};
   assign ovf       = 1'b0;
`endif

endmodule

// File: rtl/coriolis_kernel_pipe.sv
// Coriolis rotation kernel: joined (u,v) input, LANES parallel datapaths, occupancy-
// credited output buffer with forked un/vn handshakes. Saturation via CORIOLIS_SATURATE_EN.
module coriolis_kernel_pipe
   import coriolis_pkg::*;
#(
   parameter int DATAW = 34,
   parameter int FRACW = 16,
   parameter int LANES = 1,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ivalid_u,
   input  logic                   ivalid_v,
   input  logic [LANES*DATAW-1:0] u,
   input  logic [LANES*DATAW-1:0] v,
   output logic                   iready,
   output logic [LANES*DATAW-1:0] un,
   output logic [LANES*DATAW-1:0] vn,
   output logic                   ovalid_un,
   output logic                   ovalid_vn,
   input  logic                   oready_un,
   input  logic                   oready_vn,
   input  logic                   cfg_we,
   input  logic [DATAW-1:0]       coef_a,
   input  logic [DATAW-1:0]       coef_b,
   output logic                   cfg_busy,
   output logic                   ovf_sticky
);

   localparam int AW   = $clog2(DEPTH);
   localparam int PTRW = AW + 1;
   localparam int OCCW = $clog2(DEPTH + 1);
   localparam logic [OCCW-1:0] OCC_FULL = OCCW'(DEPTH);
   localparam logic signed [DATAW-1:0] COEF_ONE = DATAW'(pow2(FRACW));

   logic [OCCW-1:0]         occ;
   logic                    vld_p0, vld_p1;
   logic [PTRW-1:0]         wr_ptr, rd_ptr;
   logic                    taken_un, taken_vn;
   logic signed [DATAW-1:0] coef_a_q, coef_b_q;
   logic [LANES*DATAW-1:0]  res_un, res_vn;
   logic [LANES-1:0]        lane_ovf;
   logic [LANES*DATAW-1:0]  buf_un [DEPTH];
   logic [LANES*DATAW-1:0]  buf_vn [DEPTH];
   logic                    accept, head_vld, hs_un, hs_vn, pop;

   // iready is forced low while reset is held so nothing is accepted into a clearing pipe
   assign iready    = rst && (occ < OCC_FULL);
   assign accept    = ivalid_u & ivalid_v & iready;
   assign head_vld  = (wr_ptr != rd_ptr);
   assign ovalid_un = head_vld & ~taken_un;
   assign ovalid_vn = head_vld & ~taken_vn;
   assign hs_un     = ovalid_un & oready_un;
   assign hs_vn     = ovalid_vn & oready_vn;
   assign pop       = head_vld & (taken_un | hs_un) & (taken_vn | hs_vn);
   assign un        = head_vld ? buf_un[rd_ptr[AW-1:0]] : '0;
   assign vn        = head_vld ? buf_vn[rd_ptr[AW-1:0]] : '0;
   assign cfg_busy  = (occ != '0);

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      coriolis_lane #(
         .DATAW (DATAW),
         .FRACW (FRACW)
      ) u_lane (
         .clk    (clk),
         .u      (u[k*DATAW +: DATAW]),
         .v      (v[k*DATAW +: DATAW]),
         .coef_a (coef_a_q),
         .coef_b (coef_b_q),
         .un     (res_un[k*DATAW +: DATAW]),
         .vn     (res_vn[k*DATAW +: DATAW]),
         .ovf    (lane_ovf[k])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ      <= '0;
         vld_p0   <= 1'b0;
         vld_p1   <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         taken_un <= 1'b0;
         taken_vn <= 1'b0;
         coef_a_q <= COEF_ONE;
         coef_b_q <= '0;
      end else begin
         vld_p0 <= accept;
         vld_p1 <= vld_p0;
         if (vld_p1) wr_ptr <= wr_ptr + PTRW'(1);
         if (pop) begin
            rd_ptr   <= rd_ptr + PTRW'(1);
            taken_un <= 1'b0;
            taken_vn <= 1'b0;
         end else begin
            taken_un <= taken_un | hs_un;
            taken_vn <= taken_vn | hs_vn;
         end
         case ({accept, pop})
            2'b10:   occ <= occ + OCCW'(1);
            2'b01:   occ <= occ - OCCW'(1);
            default: occ <= occ;
         endcase
         // coefficients only change with an empty pipe so no item mixes old and new values
         if (cfg_we && (occ == '0)) begin
            coef_a_q <= coef_a;
            coef_b_q <= coef_b;
         end
      end
   end

   // stage p2 register: buffer write; occupancy credit guarantees a free slot
   always_ff @(posedge clk) begin
      if (vld_p1) begin
         buf_un[wr_ptr[AW-1:0]] <= res_un;
         buf_vn[wr_ptr[AW-1:0]] <= res_vn;
      end
   end

`ifdef CORIOLIS_SATURATE_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                      ovf_sticky <= 1'b0;
      else if (vld_p1 && |lane_ovf)  ovf_sticky <= 1'b1;
   end
`else
   logic unused_ovf;
   assign unused_ovf = |lane_ovf;
   assign ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_coriolis_kernel_pipe.sv
// Directed bench for coriolis_kernel_pipe: vector table plus handshake/reset sequences.
module tb_coriolis_kernel_pipe;
   import coriolis_pkg::*;

   localparam int DATAW = 34;

   logic             clk = 1'b0;
   logic             rst;
   logic             ivalid_u, ivalid_v, oready_un, oready_vn, cfg_we;
   logic [DATAW-1:0] u, v, coef_a, coef_b;
   logic [DATAW-1:0] un, vn;
   logic             iready, ovalid_un, ovalid_vn, cfg_busy, ovf_sticky;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [DATAW-1:0] a, b, u, v, eun, evn;
   } vec_t;

   vec_t vt[6];

   coriolis_kernel_pipe #(.DATAW(34), .FRACW(16), .LANES(1), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .ivalid_u(ivalid_u), .ivalid_v(ivalid_v), .u(u), .v(v), .iready(iready),
      .un(un), .vn(vn), .ovalid_un(ovalid_un), .ovalid_vn(ovalid_vn),
      .oready_un(oready_un), .oready_vn(oready_vn),
      .cfg_we(cfg_we), .coef_a(coef_a), .coef_b(coef_b),
      .cfg_busy(cfg_busy), .ovf_sticky(ovf_sticky)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_cfg(input logic [DATAW-1:0] a, input logic [DATAW-1:0] b);
      cfg_we = 1'b1; coef_a = a; coef_b = b;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (cfg_busy && n < 30) begin step(); n++; end
      chk({name, "_idle"}, cfg_busy, 0);
   endtask

   task automatic send1(input string name, input logic [DATAW-1:0] uu, input logic [DATAW-1:0] vv,
                        input logic [DATAW-1:0] eun, input logic [DATAW-1:0] evn);
      int n;
      chk({name, "_iready"}, iready, 1);
      ivalid_u = 1'b1; ivalid_v = 1'b1; u = uu; v = vv;
      step();
      ivalid_u = 1'b0; ivalid_v = 1'b0;
      n = 0;
      while (!(ovalid_un && ovalid_vn) && n < 10) begin step(); n++; end
      chk({name, "_ovalid"}, ovalid_un & ovalid_vn, 1);
      chk({name, "_un"}, un, eun);
      chk({name, "_vn"}, vn, evn);
      step();
   endtask

   initial begin
      int sent, recv, lowcnt, acc, vnhs, seen;

      // a, b, u, v, expected un, expected vn (Q16 in 34 bits)
      vt[0] = '{34'h0_0001_0000, 34'h0_0000_8000, 34'h0_0002_0000, 34'h0_0001_0000, 34'h0_0002_8000, 34'h0_0000_0000};
      vt[1] = '{34'h0_0001_0000, 34'h0_0000_0000, 34'h3_FFFD_0000, 34'h0_0001_8000, 34'h3_FFFD_0000, 34'h0_0001_8000};
      vt[2] = '{34'h0_0000_8000, 34'h0_0000_0000, 34'h0_0000_0001, 34'h0_0000_0003, 34'h0_0000_0001, 34'h0_0000_0002};
      vt[3] = '{34'h0_0000_8000, 34'h0_0000_0000, 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFD, 34'h0_0000_0000, 34'h3_FFFF_FFFF};
      vt[4] = '{34'h0_0000_0000, 34'h0_0001_0000, 34'h0_0001_0000, 34'h0_0002_0000, 34'h0_0002_0000, 34'h3_FFFF_0000};
      vt[5] = '{34'h0_0002_0000, 34'h0_0003_0000, 34'h0_0001_0000, 34'h3_FFFF_0000, 34'h3_FFFF_0000, 34'h3_FFFB_0000};

      rst = 1'b0; ivalid_u = 1'b0; ivalid_v = 1'b0; u = '0; v = '0;
      oready_un = 1'b1; oready_vn = 1'b1; cfg_we = 1'b0; coef_a = '0; coef_b = '0;
      step(); step();
      chk("rst_ovalid_un", ovalid_un, 0);
      chk("rst_ovalid_vn", ovalid_vn, 0);
      chk("rst_iready", iready, 0);
      chk("rst_un", un, 0);
      chk("rst_busy", cfg_busy, 0);
      chk("rst_ovf", ovf_sticky, 0);
      rst = 1'b1;
      #1;
      chk("rel_iready", iready, 1);
      step();

      // reset coefficients are a=1.0, b=0
      send1("rstcoef", 34'h3_0000 , 34'h1_0000, 34'h3_0000, 34'h1_0000);

      // latency: result visible on the third edge after the accepting edge
      load_cfg(vt[0].a, vt[0].b);
      ivalid_u = 1'b1; ivalid_v = 1'b1; u = vt[0].u; v = vt[0].v;
      step();
      ivalid_u = 1'b0; ivalid_v = 1'b0;
      chk("lat_c2", ovalid_un, 0);
      chk("lat_busy", cfg_busy, 1);
      step();
      chk("lat_c3", ovalid_un, 0);
      step();
      chk("lat_c4_un", ovalid_un, 1);
      chk("lat_c4_vn", ovalid_vn, 1);
      chk("lat_un", un, 34'h2_8000);
      chk("lat_vn", vn, 0);
      step();
      wait_idle("lat");

      for (int i = 0; i < 6; i++) begin
         load_cfg(vt[i].a, vt[i].b);
         send1($sformatf("vec%0d", i), vt[i].u, vt[i].v, vt[i].eun, vt[i].evn);
      end

      // streaming at one item per cycle
      load_cfg(34'h1_0000, 34'h0);
      sent = 0; recv = 0; lowcnt = 0;
      for (int c = 0; c < 40; c++) begin
         if (ovalid_un && ovalid_vn) begin
            chk($sformatf("stream_un%0d", recv), un, longint'(recv) * 64'h1_0000);
            chk($sformatf("stream_vn%0d", recv), vn, longint'(recv) * 64'h8000);
            recv++;
         end
         ivalid_u = (sent < 20); ivalid_v = (sent < 20);
         u = DATAW'(longint'(sent) * 64'h1_0000);
         v = DATAW'(longint'(sent) * 64'h8000);
         if (sent < 20 && !iready) lowcnt++;
         if (ivalid_u && iready) sent++;
         step();
      end
      ivalid_u = 1'b0; ivalid_v = 1'b0;
      chk("stream_recv", recv, 20);
      chk("stream_iready_low", lowcnt, 0);

      // un side stalled: vn taken once, buffer fills, release pops head
      oready_un = 1'b0; acc = 0; vnhs = 0;
      for (int c = 0; c < 8; c++) begin
         if (ovalid_vn && oready_vn) vnhs++;
         ivalid_u = 1'b1; ivalid_v = 1'b1;
         u = DATAW'(longint'(acc + 1) * 64'h1_0000); v = '0;
         if (iready) acc++;
         step();
      end
      ivalid_u = 1'b0; ivalid_v = 1'b0;
      chk("bp_accepts", acc, 4);
      chk("bp_vn_hs", vnhs, 1);
      chk("bp_ovalid_vn", ovalid_vn, 0);
      chk("bp_ovalid_un", ovalid_un, 1);
      chk("bp_un_head", un, 34'h1_0000);
      chk("full_iready", iready, 0);
      oready_un = 1'b1;
      step();
      chk("pop_iready", iready, 1);
      chk("pop_ovalid_vn", ovalid_vn, 1);
      chk("pop_un_next", un, 34'h2_0000);
      wait_idle("bp");

      // cfg write ignored while items are in flight
      ivalid_u = 1'b1; ivalid_v = 1'b1; u = 34'h1_0000; v = '0;
      step(); step();
      ivalid_u = 1'b0; ivalid_v = 1'b0;
      chk("cfg_busy2", cfg_busy, 1);
      load_cfg(34'h2_0000, 34'h1_0000);
      wait_idle("cfg");
      send1("cfg_ignored", 34'h1_0000, 34'h0, 34'h1_0000, 34'h0);
      load_cfg(34'h2_0000, 34'h1_0000);
      send1("cfg_applied", 34'h1_0000, 34'h0, 34'h2_0000, 34'h3_FFFF_0000);

      // large operands: clamp or wrap
      chk("pre_ovf", ovf_sticky, 0);
      load_cfg(34'h1_FFFF_0000, 34'h1_FFFF_0000);
`ifdef CORIOLIS_SATURATE_EN
      send1("sat", 34'h1_FFFF_0000, 34'h1_FFFF_0000, 34'h1_FFFF_FFFF, 34'h0);
      chk("sat_ovf", ovf_sticky, 1);
`else
      send1("wrap", 34'h1_FFFF_0000, 34'h1_FFFF_0000, 34'h0_0002_0000, 34'h0);
      chk("wrap_ovf", ovf_sticky, 0);
`endif

      // reset with items buffered discards them
      load_cfg(34'h1_0000, 34'h0);
      oready_un = 1'b0; oready_vn = 1'b0;
      ivalid_u = 1'b1; ivalid_v = 1'b1; u = 34'h7_0000; v = 34'h7_0000;
      step(); step(); step();
      ivalid_u = 1'b0; ivalid_v = 1'b0;
      step(); step();
      chk("mid_ovalid", ovalid_un, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_ovalid_un", ovalid_un, 0);
      chk("mid_rst_ovalid_vn", ovalid_vn, 0);
      chk("mid_rst_busy", cfg_busy, 0);
      chk("mid_rst_ovf", ovf_sticky, 0);
      step();
      rst = 1'b1;
      oready_un = 1'b1; oready_vn = 1'b1;
      #1;
      chk("mid_rel_iready", iready, 1);
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (ovalid_un || ovalid_vn) seen++;
      end
      chk("mid_no_stale", seen, 0);
      send1("post_rst", 34'h2_0000, 34'h1_0000, 34'h2_0000, 34'h1_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/coriolis_kernel_pipe.md
CORIOLIS_KERNEL_PIPE -- requirements
Module: coriolis_kernel_pipe

Interface
REQ-001 Parameter DATAW, 34, signed fixed-point width of every stream and coefficient word.
REQ-002 Parameter FRACW, 16, fractional bits of all operands and results.
REQ-003 Parameter LANES, 1, parallel (u,v) pairs per transfer; all lanes share one handshake.
REQ-004 Parameter DEPTH, 4, output buffer entries, power of two, >= 4.
REQ-005 clk  in  1  single clock; all flops on rising edge.
REQ-006 rst  in  1  reset, asynchronous assert, active-low; deassertion synchronous to clk externally.
REQ-007 ivalid_u, ivalid_v  in  1 each  input stream valids.
REQ-008 u, v  in  LANES*DATAW each  input streams; lane k at bits [k*DATAW +: DATAW].
REQ-009 iready  out  1  common ready to both input streams.
REQ-010 un, vn  out  LANES*DATAW each  result streams, same lane packing.
REQ-011 ovalid_un, ovalid_vn  out  1 each; oready_un, oready_vn  in  1 each  independent output handshakes.
REQ-012 cfg_we  in  1; coef_a, coef_b  in  DATAW each  coefficient load port.
REQ-013 cfg_busy  out  1  high while any item is in flight or buffered; ovf_sticky  out  1  saturation flag.

Function
REQ-014 Per lane: un = u*coef_a + v*coef_b; vn = v*coef_a - u*coef_b; full 2*DATAW+1 precision before scaling.
REQ-015 Scaling: add 2^(FRACW-1), arithmetic shift right FRACW (round half up), then reduce to DATAW per REQ-030.
REQ-016 Input accepted only when ivalid_u & ivalid_v & iready in the same cycle (join); iready never depends on ivalid_*.
REQ-017 Datapath: fixed 3-stage pipeline (multiply, add/sub+round, reduce); accepted item enters buffer 3 cycles after acceptance, first visible on outputs in cycle 4.
REQ-018 Occupancy counter occ (0..DEPTH) covers pipeline plus buffer: +1 on accept, -1 on buffer pop, both same cycle = unchanged.
REQ-019 iready = (occ < DEPTH); pipeline never stalls, buffer never overflows.
REQ-020 With DEPTH >= 4 and both oready high, sustained throughput is one transfer per cycle.
REQ-021 Output fork: ovalid_un = head valid & ~taken_un; ovalid_vn = head valid & ~taken_vn; taken_x set on ovalid_x & oready_x.
REQ-022 Head popped (taken flags cleared) in the cycle the second of the two outputs is accepted, including both accepted in the same cycle.
REQ-023 un/vn hold stable while their ovalid is high and unaccepted.
REQ-024 cfg_we samples coef_a/coef_b only when occ == 0; ignored otherwise; new coefficients apply to the next accepted input.
REQ-025 cfg_busy = (occ != 0).
REQ-026 Buffer full (occ == DEPTH) with simultaneous pop: iready low that cycle, high next cycle.

Reset
REQ-027 On rst low: occ, taken flags, pipe valids, buffer pointers = 0; ovalid_* = 0; un/vn = 0; iready = 0; ovf_sticky = 0.
REQ-028 Reset coefficients: coef_a = 2^FRACW (1.0), coef_b = 0.
REQ-029 Reset mid-operation discards all in-flight and buffered items; iready = 1 first cycle after release.

Configuration
REQ-030 CORIOLIS_SATURATE_EN defined: results clamp to [-2^(DATAW-1), 2^(DATAW-1)-1]; ovf_sticky sets on any lane clamp, cleared only by reset.
REQ-031 CORIOLIS_SATURATE_EN undefined: results truncated to low DATAW bits (two's-complement wrap); ovf_sticky tied 0.

Structure
REQ-032 Package coriolis_pkg holds LAT = 3, rounding-constant function, and saturation bounds functions of DATAW.
REQ-033 One sub-module coriolis_lane: single-lane 3-stage datapath, instantiated LANES times; control, occ, buffer and fork in top.

Verification (DATAW=34, FRACW=16, LANES=1, DEPTH=4)
REQ-034 Reset, cfg a=0x10000, b=0x8000, u=0x20000, v=0x10000 -> un=0x28000, vn=0x0 with ovalid in cycle 4 after accept.
REQ-035 Continuous input, both oready high -> 1 result/cycle, iready never low after warm-up.
REQ-036 oready_un held low, oready_vn high -> vn accepted once, ovalid_vn low thereafter; iready low after 4 accepts; oready_un release pops head.
REQ-037 a=b=0x1FFFF0000, u=v=0x1FFFF0000 -> with SATURATE_EN un=0x1FFFFFFFF, ovf_sticky=1; without, truncated value, ovf_sticky=0.
REQ-038 cfg_we pulsed with occ=2 -> coefficients unchanged; pulsed at occ=0 -> new values used on next input.
REQ-039 rst asserted with 3 items buffered -> ovalid_* drop immediately, no stale item output after release.
